// File: rtl/mips_core_pkg.sv
// Shared write-path definitions.
//   ADDR_WIDTH / DATA_WIDTH : external AXI address and data widths
//   AXI_ID_WIDTH            : width of awid / wid (master index)
//   wr_order_t              : one order-FIFO entry {master id, burst len}
package mips_core_pkg;

   localparam int ADDR_WIDTH   = 32;
   localparam int DATA_WIDTH   = 32;
   localparam int AXI_ID_WIDTH = 4;

   typedef struct packed {
      logic [3:0] id;
      logic [3:0] len;
   } wr_order_t;

endpackage

// File: rtl/wr_order_fifo.sv
// Order FIFO recording AW grant order so W bursts are replayed in the same order.
//   clk, rst_n  : clock, synchronous active-low reset (clears pointers/count)
//   push        : write push_data (ignored when full, even if popping)
//   push_data   : {id, len} of the granted AW
//   pop         : drop the head entry (ignored when empty)
//   head        : oldest entry, valid while !empty
//   full, empty : occupancy flags
module wr_order_fifo
   import mips_core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  wr_order_t push_data,
   input  logic      pop,
   output wr_order_t head,
   output logic      full,
   output logic      empty
);

   localparam int PTR_W = $clog2(DEPTH);

   wr_order_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
   end

   // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; entries are only read after being written, so count gates validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/write_channel_scheduler.sv
// Write-path scheduler: round-robin AW arbitration across COUNT masters, grant
// order kept in an order FIFO, W channel locked to the FIFO-head master until
// its burst's last beat so W beats never interleave and follow AW order.
//   clk, rst_n                 : clock, synchronous active-low reset
//   m_awvalid/m_awready        : per-master AW handshake
//   m_awlen, m_awaddr          : per-master AW payload (len = beats-1, 0..7)
//   m_wvalid/m_wready          : per-master W handshake (ready only for head)
//   m_wlast, m_wdata           : per-master W payload (wlast is checked only)
//   awvalid/awready, awid, awlen, awaddr : external AW channel
//   wvalid/wready, wid, wlast, wdata     : external W channel
//   err_wlast                  : sticky, master WLAST disagreed with generated WLAST
module write_channel_scheduler
   import mips_core_pkg::*;
#(
   parameter int COUNT      = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [COUNT-1:0]                    m_awvalid,
   output logic [COUNT-1:0]                    m_awready,
   input  logic [COUNT-1:0][3:0]               m_awlen,
   input  logic [COUNT-1:0][ADDR_WIDTH-1:0]    m_awaddr,
   input  logic [COUNT-1:0]                    m_wvalid,
   output logic [COUNT-1:0]                    m_wready,
   input  logic [COUNT-1:0]                    m_wlast,
   input  logic [COUNT-1:0][DATA_WIDTH-1:0]    m_wdata,
   output logic                                awvalid,
   input  logic                                awready,
   output logic [AXI_ID_WIDTH-1:0]             awid,
   output logic [3:0]                          awlen,
   output logic [ADDR_WIDTH-1:0]               awaddr,
   output logic                                wvalid,
   input  logic                                wready,
   output logic [AXI_ID_WIDTH-1:0]             wid,
   output logic                                wlast,
   output logic [DATA_WIDTH-1:0]               wdata,
   output logic                                err_wlast
);

   logic [3:0]              rr_ptr_q, rr_ptr_d;
   logic                    awvalid_q, awvalid_d;
   logic [3:0]              awid_q, awid_d;
   logic [3:0]              awlen_q, awlen_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic                    wvalid_q, wvalid_d;
   logic [3:0]              wid_q, wid_d;
   logic                    wlast_q, wlast_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [2:0]              beat_cnt_q, beat_cnt_d;
   logic                    err_wlast_q, err_wlast_d;

   logic                    fifo_full, fifo_empty, fifo_pop;
   wr_order_t               head, push_entry;
   logic                    found, aw_load, aw_accept, w_load, w_accept, gen_last;
   logic [3:0]              winner, sel_awlen;
   logic [ADDR_WIDTH-1:0]   sel_awaddr;
   logic                    sel_wvalid, sel_wlast;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   wr_order_fifo #(.DEPTH(FIFO_DEPTH)) u_order_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (aw_accept),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Round-robin: first look above rr_ptr, then wrap around to 0..rr_ptr.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < COUNT; i++) begin
         if (!found && m_awvalid[i] && (4'(i) > rr_ptr_q)) begin
            found  = 1'b1;
            winner = 4'(i);
         end
      end
      for (int i = 0; i < COUNT; i++) begin
         if (!found && m_awvalid[i] && (4'(i) <= rr_ptr_q)) begin
            found  = 1'b1;
            winner = 4'(i);
         end
      end
   end

   // Ready gating includes rst_n so masters never see ready during reset.
   assign aw_load    = rst_n && (awready || !awvalid_q) && !fifo_full;
   assign aw_accept  = aw_load && found;
   assign w_load     = rst_n && (wready || !wvalid_q) && !fifo_empty;
   assign gen_last   = ({1'b0, beat_cnt_q} == head.len);
   assign w_accept   = w_load && sel_wvalid;
   assign fifo_pop   = w_accept && gen_last;
   assign push_entry = '{id: winner, len: sel_awlen};

   // Payload muxes and per-master ready steering.
   always_comb begin
      sel_awlen  = '0;
      sel_awaddr = '0;
      sel_wvalid = 1'b0;
      sel_wlast  = 1'b0;
      sel_wdata  = '0;
      m_awready  = '0;
      m_wready   = '0;
      for (int i = 0; i < COUNT; i++) begin
         if (4'(i) == winner) begin
            sel_awlen    = m_awlen[i];
            sel_awaddr   = m_awaddr[i];
            m_awready[i] = aw_accept;
         end
         if (4'(i) == head.id) begin
            sel_wvalid  = m_wvalid[i];
            sel_wlast   = m_wlast[i];
            sel_wdata   = m_wdata[i];
            m_wready[i] = w_load;
         end
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      awvalid_d   = awvalid_q;
      awid_d      = awid_q;
      awlen_d     = awlen_q;
      awaddr_d    = awaddr_q;
      wvalid_d    = wvalid_q;
      wid_d       = wid_q;
      wlast_d     = wlast_q;
      wdata_d     = wdata_q;
      beat_cnt_d  = beat_cnt_q;
      err_wlast_d = err_wlast_q;

      if (aw_accept) begin
         rr_ptr_d  = winner;
         awvalid_d = 1'b1;
         awid_d    = winner;
         awlen_d   = sel_awlen;
         awaddr_d  = sel_awaddr;
      end else if (awready) begin
         awvalid_d = 1'b0;
      end

      if (w_accept) begin
         wvalid_d   = 1'b1;
         wid_d      = head.id;
         wlast_d    = gen_last;
         wdata_d    = sel_wdata;
         beat_cnt_d = gen_last ? 3'd0 : beat_cnt_q + 3'd1;
         // Length always follows the recorded awlen; a wrong master WLAST is only flagged.
         if (sel_wlast != gen_last) err_wlast_d = 1'b1;
      end else if (wready) begin
         wvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q    <= 4'(COUNT - 1);
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         beat_cnt_q  <= '0;
         err_wlast_q <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         beat_cnt_q  <= beat_cnt_d;
         err_wlast_q <= err_wlast_d;
      end
   end

   // Payload registers carry no reset; the valid flags qualify them.
   always_ff @(posedge clk) begin
      awid_q   <= awid_d;
      awlen_q  <= awlen_d;
      awaddr_q <= awaddr_d;
      wid_q    <= wid_d;
      wlast_q  <= wlast_d;
      wdata_q  <= wdata_d;
   end

   assign awvalid   = awvalid_q;
   assign awid      = awid_q;
   assign awlen     = awlen_q;
   assign awaddr    = awaddr_q;
   assign wvalid    = wvalid_q;
   assign wid       = wid_q;
   assign wlast     = wlast_q;
   assign wdata     = wdata_q;
   assign err_wlast = err_wlast_q;

endmodule

// File: tb/tb_write_channel_scheduler.sv
// Bench for write_channel_scheduler: random masters/backpressure checked against a
// transaction-level model (grant rule, outstanding-burst limit, AW-order W replay),
// followed by directed WLAST-error and mid-burst reset scenarios.
module tb_write_channel_scheduler;
   import mips_core_pkg::*;

   localparam int COUNT = 2;
   localparam int DEPTH = 4;
   localparam int NB    = 40;

   logic                             clk = 1'b0;
   logic                             rst_n;
   logic [COUNT-1:0]                 m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
   logic [COUNT-1:0][3:0]            m_awlen;
   logic [COUNT-1:0][ADDR_WIDTH-1:0] m_awaddr;
   logic [COUNT-1:0][DATA_WIDTH-1:0] m_wdata;
   logic                             awvalid, awready, wvalid, wready, wlast, err_wlast;
   logic [AXI_ID_WIDTH-1:0]          awid, wid;
   logic [3:0]                       awlen;
   logic [ADDR_WIDTH-1:0]            awaddr;
   logic [DATA_WIDTH-1:0]            wdata;

   write_channel_scheduler #(.COUNT(COUNT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awlen(m_awlen), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wid(wid), .wlast(wlast), .wdata(wdata),
      .err_wlast(err_wlast)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
   endtask

   // ---------------- reference model state ----------------
   typedef struct packed {
      logic [3:0]            id;
      logic [3:0]            len;
      logic [ADDR_WIDTH-1:0] addr;
   } aw_exp_t;

   typedef struct packed {
      logic [3:0]            id;
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } w_exp_t;

   aw_exp_t    exp_aw[$];
   w_exp_t     exp_w[$];
   int         ord[$];              // grant order of bursts whose W is not yet fully accepted
   logic [3:0] lens [COUNT][NB];
   int         aw_seq [COUNT];
   int         w_seq  [COUNT];
   int         w_beat [COUNT];
   bit         aw_hs  [COUNT];
   bit         w_hs   [COUNT];
   int         last_grant;
   bit         aw_full_m, w_full_m;
   int         w_prob;

   function automatic logic [ADDR_WIDTH-1:0] mk_addr(int i, int s);
      return (32'(i) << 24) | (32'(s) << 6);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] mk_data(int i, int s, int b);
      return {4'(i), 12'(s), 8'(b), 8'h5A};
   endfunction

   function automatic bit rand_done();
      bit d = (ord.size() == 0) && (exp_aw.size() == 0) && (exp_w.size() == 0)
              && !aw_full_m && !w_full_m;
      for (int i = 0; i < COUNT; i++) if (aw_seq[i] != NB) d = 1'b0;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m_awvalid = '0; m_awlen = '0; m_awaddr = '0;
      m_wvalid  = '0; m_wlast = '0; m_wdata  = '0;
      awready   = 1'b0; wready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Masters keep valid asserted until handshake; payload only advances on handshake.
   task automatic drive_random();
      for (int i = 0; i < COUNT; i++) begin
         if (!(m_awvalid[i] && !aw_hs[i]))
            m_awvalid[i] = (aw_seq[i] < NB) && ($urandom_range(0, 3) != 0);
         if (aw_seq[i] < NB) begin
            m_awlen[i]  = lens[i][aw_seq[i]];
            m_awaddr[i] = mk_addr(i, aw_seq[i]);
         end
         if (!(m_wvalid[i] && !w_hs[i]))
            m_wvalid[i] = (w_seq[i] < aw_seq[i]) && ($urandom_range(0, 3) != 0);
         if (w_seq[i] < aw_seq[i]) begin
            m_wdata[i] = mk_data(i, w_seq[i], w_beat[i]);
            m_wlast[i] = (w_beat[i] == int'(lens[i][w_seq[i]]));
         end
      end
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 99) < w_prob);
   endtask

   // Evaluated mid-cycle: compares outputs, then advances the model across the next edge.
   task automatic eval_cycle();
      logic [COUNT-1:0] exp_awr, exp_wr;
      bit               aw_ld, w_ld, w_acc;
      int               win, h;
      aw_exp_t          ea;
      w_exp_t           ew;

      check("awvalid", awvalid, aw_full_m);
      check("wvalid", wvalid, w_full_m);

      if (aw_full_m && awready && exp_aw.size() > 0) begin
         ea = exp_aw.pop_front();
         check("awid", awid, ea.id);
         check("awlen", awlen, ea.len);
         check("awaddr", awaddr, ea.addr);
      end
      if (w_full_m && wready && exp_w.size() > 0) begin
         ew = exp_w.pop_front();
         check("wid", wid, ew.id);
         check("wdata", wdata, ew.data);
         check("wlast", wlast, ew.last);
      end

      // Grant rule: first requester after the last granted index, if a slot is free.
      aw_ld = (ord.size() < DEPTH) && (!aw_full_m || awready);
      win   = -1;
      for (int k = 1; k <= COUNT; k++)
         if (win < 0 && m_awvalid[(last_grant + k) % COUNT]) win = (last_grant + k) % COUNT;
      exp_awr = '0;
      if (aw_ld && win >= 0) exp_awr[win] = 1'b1;

      w_ld   = (ord.size() > 0) && (!w_full_m || wready);
      exp_wr = '0;
      w_acc  = 1'b0;
      h      = 0;
      if (w_ld) begin
         h         = ord[0];
         exp_wr[h] = 1'b1;
         w_acc     = m_wvalid[h];
      end
      check("m_awready", m_awready, exp_awr);
      check("m_wready", m_wready, exp_wr);

      for (int i = 0; i < COUNT; i++) begin
         aw_hs[i] = 1'b0;
         w_hs[i]  = 1'b0;
      end
      if (w_acc) begin
         w_hs[h] = 1'b1;
         if (w_beat[h] == int'(lens[h][w_seq[h]])) begin
            w_beat[h] = 0;
            w_seq[h]++;
            void'(ord.pop_front());
         end else begin
            w_beat[h]++;
         end
      end
      if (aw_ld && win >= 0) begin
         aw_hs[win] = 1'b1;
         last_grant = win;
         ea.id   = 4'(win);
         ea.len  = lens[win][aw_seq[win]];
         ea.addr = mk_addr(win, aw_seq[win]);
         exp_aw.push_back(ea);
         for (int b = 0; b <= int'(ea.len); b++) begin
            ew.id   = 4'(win);
            ew.data = mk_data(win, aw_seq[win], b);
            ew.last = (b == int'(ea.len));
            exp_w.push_back(ew);
         end
         ord.push_back(win);
         aw_seq[win]++;
      end
      aw_full_m = (aw_ld && win >= 0) ? 1'b1 : (awready ? 1'b0 : aw_full_m);
      w_full_m  = w_acc ? 1'b1 : (wready ? 1'b0 : w_full_m);
   endtask

   initial begin
      // ---------------- reset state ----------------
      clear_inputs();
      rst_n     = 1'b0;
      m_awvalid = '1;
      m_wvalid  = '1;
      awready   = 1'b1;
      wready    = 1'b1;
      tick();
      tick();
      check("rst_awvalid", awvalid, 1'b0);
      check("rst_wvalid", wvalid, 1'b0);
      check("rst_err", err_wlast, 1'b0);
      check("rst_m_awready", m_awready, '0);
      check("rst_m_wready", m_wready, '0);
      clear_inputs();
      rst_n = 1'b1;
      tick();

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < COUNT; i++) begin
         aw_seq[i] = 0; w_seq[i] = 0; w_beat[i] = 0;
         aw_hs[i] = 1'b0; w_hs[i] = 1'b0;
         for (int s = 0; s < NB; s++) lens[i][s] = 4'($urandom_range(0, 7));
      end
      last_grant = COUNT - 1;
      aw_full_m  = 1'b0;
      w_full_m   = 1'b0;
      w_prob     = 15;
      for (int cyc = 0; cyc < 20000 && !rand_done(); cyc++) begin
         if (cyc % 150 == 0) w_prob = (w_prob == 90) ? 15 : 90;
         drive_random();
         @(negedge clk);
         eval_cycle();
         @(posedge clk);
         #1;
      end
      check("random_drained", rand_done(), 1'b1);
      check("random_err_wlast", err_wlast, 1'b0);

      // ---------------- WLAST mismatch ----------------
      clear_inputs();
      do_reset();
      awready = 1'b1;
      wready  = 1'b1;
      m_awvalid[0] = 1'b1; m_awlen[0] = 4'd1; m_awaddr[0] = 32'h100;
      #1;
      check("err_m_awready", m_awready, 2'b01);
      tick();
      m_awvalid = '0;
      check("err_awvalid", awvalid, 1'b1);
      check("err_awid", awid, 4'd0);
      m_wvalid[0] = 1'b1; m_wdata[0] = 32'hD0; m_wlast[0] = 1'b1;
      #1;
      check("err_m_wready", m_wready, 2'b01);
      tick();
      check("err_beat1", {wvalid, wlast}, 2'b10);
      check("err_set", err_wlast, 1'b1);
      m_wdata[0] = 32'hD1; m_wlast[0] = 1'b0;
      tick();
      check("err_beat2", {wvalid, wlast}, 2'b11);
      check("err_beat2_wdata", wdata, 32'hD1);
      m_wvalid = '0;
      repeat (3) tick();
      check("err_sticky", err_wlast, 1'b1);
      do_reset();
      check("err_cleared", err_wlast, 1'b0);

      // ---------------- reset in the middle of a len=7 burst ----------------
      clear_inputs();
      awready = 1'b1;
      wready  = 1'b1;
      m_awvalid[1] = 1'b1; m_awlen[1] = 4'd7; m_awaddr[1] = 32'h300;
      tick();
      m_awvalid = '0;
      check("mid_awid", awid, 4'd1);
      m_wvalid[1] = 1'b1; m_wdata[1] = 32'hE0; m_wlast[1] = 1'b0;
      tick();
      check("mid_beat1", {wvalid, wid}, {1'b1, 4'd1});
      m_wdata[1]   = 32'hE1;
      m_awvalid[0] = 1'b1; m_awlen[0] = 4'd0; m_awaddr[0] = 32'h400;
      rst_n = 1'b0;
      #1;
      check("mid_rst_m_ready", {m_awready, m_wready}, '0);
      tick();
      check("mid_rst_valids", {awvalid, wvalid}, 2'b00);
      rst_n    = 1'b1;
      m_wvalid = '0;
      m_awvalid = 2'b11; m_awlen[1] = 4'd0;
      #1;
      check("post_rst_fifo_empty", m_wready, '0);
      check("post_rst_grant", m_awready, 2'b01);
      tick();
      m_awvalid = '0;
      check("post_rst_aw", {awvalid, awid}, {1'b1, 4'd0});
      check("post_rst_awaddr", awaddr, 32'h400);
      m_wvalid[0] = 1'b1; m_wdata[0] = 32'hF0; m_wlast[0] = 1'b1;
      #1;
      check("post_rst_m_wready", m_wready, 2'b01);
      tick();
      m_wvalid = '0;
      check("post_rst_w", {wvalid, wid, wlast}, {1'b1, 4'd0, 1'b1});
      check("post_rst_wdata", wdata, 32'hF0);
      check("post_rst_err", err_wlast, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
